// File: rtl/custom_axi_regs.sv
// AXI4-Lite register file in front of the custom IP core.
// It holds the operand, issues the start pulse, and captures the result and status for readback.
module custom_axi_regs #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   ipreg_data_o,
    output logic                    ip_enable_o,
    input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
    input  logic [1:0]              ip_status_i
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DONE     = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DATA    = 2'd1;
    localparam logic [1:0] REG_RESULT  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  r_out_en;
    logic                  r_aw_held;
    logic [1:0]            r_aw_sel;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_done_s;
    logic                  r_ign_s;
    logic                  r_ip_enable;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_start;
    logic                  w_clr;
    logic [DATA_WIDTH-1:0] w_data_merged;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    // Byte-lane address bits are not decoded.
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = r_out_en & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = r_out_en & ~r_w_held & ~r_bvalid;
    assign s_axi_arready = r_out_en & ~r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = RESP_OKAY;
    assign ipreg_data_o  = r_data_in;
    assign ip_enable_o   = r_ip_enable;

    assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_w_hs   = s_axi_wvalid & s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_commit = r_aw_held & r_w_held;
    assign w_start  = w_commit & (r_aw_sel == REG_CTRL) & r_wstrb[0] & r_wdata[0];
    assign w_clr    = w_commit & (r_aw_sel == REG_CTRL) & r_wstrb[0] & r_wdata[1];

    // Merge held write data into DATA_IN honouring byte strobes.
    always_comb begin
        w_data_merged = r_data_in;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (r_wstrb[b]) begin
                w_data_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    // Read mux over the register map, sampled at the AR handshake.
    always_comb begin
        w_rd_data = '0;
        case (s_axi_araddr[3:2])
            REG_CTRL:   w_rd_data = '0;
            REG_DATA:   w_rd_data = r_data_in;
            REG_RESULT: w_rd_data = r_result;
            default:    w_rd_data = {{(DATA_WIDTH-6){1'b0}}, r_ign_s, r_done_s, 2'b00, ip_status_i};
        endcase
    end

    // Keep READY low while reset is asserted and for the first cycle after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_out_en <= 1'b0;
        else       r_out_en <= 1'b1;
    end

    // Write channel: independent AW/W capture, commit, then hold B until bready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_held <= 1'b0;
            r_aw_sel  <= 2'd0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_sel  <= s_axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= r_aw_sel[1] ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register updates, start pulse and sticky status; sticky sets win over clears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_in   <= '0;
            r_result    <= '0;
            r_done_s    <= 1'b0;
            r_ign_s     <= 1'b0;
            r_ip_enable <= 1'b0;
        end else begin
            r_ip_enable <= w_start & (ip_status_i == ST_IDLE);
            if (w_commit && r_aw_sel == REG_DATA) r_data_in <= w_data_merged;
            if (ip_status_i == ST_DONE) r_result <= ipreg_data_i;
            if (ip_status_i == ST_DONE)                 r_done_s <= 1'b1;
            else if (w_clr)                             r_done_s <= 1'b0;
            if (w_start && ip_status_i != ST_IDLE)      r_ign_s  <= 1'b1;
            else if (w_clr)                             r_ign_s  <= 1'b0;
        end
    end

    // Read channel: capture data on AR handshake, hold until rready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_custom_axi_regs.sv
// Directed and randomized bench for custom_axi_regs with a register-map reference model.
module tb_custom_axi_regs;
    logic        clk;
    logic        rst;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ip_data_out;
    logic        ip_en;
    logic [31:0] ip_data_in;
    logic [1:0]  status;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;

    // Reference model state (bench view of the register map)
    logic [31:0] m_data_in;
    logic [31:0] m_result;
    logic        m_done;
    logic        m_ign;

    custom_axi_regs dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ipreg_data_o(ip_data_out), .ip_enable_o(ip_en),
        .ipreg_data_i(ip_data_in), .ip_status_i(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the start pulse high.
    always @(negedge clk) if (ip_en === 1'b1) en_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int  n;
        logic hs_aw, hs_w;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            hs_aw = awvalid & awready;
            hs_w  = wvalid & wready;
            tick();
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) chk("wr_accept_timeout", {30'd0, awvalid, wvalid}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) chk("wr_bvalid_timeout", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) chk("rd_arready_timeout", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) chk("rd_rvalid_timeout", {31'd0, rvalid}, 32'd1);
        data = rdata; resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    // Model: apply a write to the register map; returns expected response and pulse.
    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] exp_resp, output int exp_pulse);
        exp_pulse = 0;
        exp_resp  = (addr >= 4'd8) ? 2'b10 : 2'b00;
        if (addr < 4'd4) begin
            if (strb[0] && data[1]) begin m_ign = 1'b0; if (status != 2'd2) m_done = 1'b0; end
            if (strb[0] && data[0]) begin
                if (status == 2'd0) exp_pulse = 1;
                else                m_ign = 1'b1;
            end
        end else if (addr < 4'd8) begin
            for (int b = 0; b < 4; b++) if (strb[b]) m_data_in[b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr / 4)
            0:       return 32'd0;
            1:       return m_data_in;
            2:       return m_result;
            default: return {26'd0, m_ign, m_done, 2'b00, status};
        endcase
    endfunction

    initial begin : main
        logic [31:0] d, d0, exp_d;
        logic [1:0]  r, exp_r;
        logic [3:0]  a, s;
        int          e0, exp_p;

        rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; ip_data_in = '0; status = 2'd0;
        m_data_in = '0; m_result = '0; m_done = 0; m_ign = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_enable",  {31'd0, ip_en},   32'd0);
        rst = 1'b0;
        tick();
        axi_read(4'h4, d, r);
        chk("rst_data_in", d, 32'h0);
        chk("rst_rresp", {30'd0, r}, 32'd0);

        // Full-word then partial-strobe write to DATA_IN
        axi_write(4'h4, 32'hDEADBEEF, 4'hF, r); model_write(4'h4, 32'hDEADBEEF, 4'hF, exp_r, exp_p);
        chk("wr_full_bresp", {30'd0, r}, {30'd0, exp_r});
        axi_write(4'h4, 32'h000000AA, 4'h1, r); model_write(4'h4, 32'h000000AA, 4'h1, exp_r, exp_p);
        chk("wr_strb_bresp", {30'd0, r}, {30'd0, exp_r});
        chk("wr_strb_ipreg", ip_data_out, 32'hDEADBEAA);
        axi_read(4'h4, d, r);
        chk("wr_strb_readback", d, 32'hDEADBEAA);

        // AW early, W three cycles later, B back-pressured for four cycles
        awaddr = 4'h4; awvalid = 1'b1;
        chk("aw_early_ready", {31'd0, awready}, 32'd1);
        tick(); awvalid = 1'b0;
        chk("aw_held_noready", {31'd0, awready}, 32'd0);
        repeat (3) begin chk("w_wait_ready", {31'd0, wready}, 32'd1); tick(); end
        d0 = $urandom;
        wdata = d0; wstrb = 4'hF; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        tick();
        model_write(4'h4, d0, 4'hF, exp_r, exp_p);
        awvalid = 1'b1; wvalid = 1'b1; wdata = ~d0;
        repeat (4) begin
            chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
            chk("bp_bresp", {30'd0, bresp}, 32'd0);
            chk("bp_no_accept", {30'd0, awready, wready}, 32'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; tick(); bready = 1'b0;
        chk("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
        chk("bp_ipreg", ip_data_out, m_data_in);

        // START while IDLE, then core runs to DONE
        status = 2'd0;
        e0 = en_cnt;
        axi_write(4'h0, 32'h1, 4'hF, r); model_write(4'h0, 32'h1, 4'hF, exp_r, exp_p);
        repeat (3) tick();
        chk("start_pulse_count", 32'(en_cnt - e0), 32'(exp_p));
        chk("start_bresp", {30'd0, r}, 32'd0);
        status = 2'd1; repeat (2) tick();
        ip_data_in = 32'hDEADBEAB; status = 2'd2; repeat (2) tick();
        m_done = 1'b1; m_result = ip_data_in;
        axi_read(4'h8, d, r);
        chk("result_read", d, 32'hDEADBEAB);
        axi_read(4'hC, d, r);
        chk("status_done", d, 32'h12);

        // START while BUSY is ignored and flagged; CLR_STICKY clears both sticky bits
        status = 2'd1; tick();
        e0 = en_cnt;
        axi_write(4'h0, 32'h1, 4'h1, r); model_write(4'h0, 32'h1, 4'h1, exp_r, exp_p);
        repeat (3) tick();
        chk("busy_no_pulse", 32'(en_cnt - e0), 32'(exp_p));
        chk("busy_bresp", {30'd0, r}, {30'd0, exp_r});
        axi_read(4'hC, d, r);
        chk("busy_status_ign", d, model_read(4'hC));
        axi_write(4'h0, 32'h2, 4'h1, r); model_write(4'h0, 32'h2, 4'h1, exp_r, exp_p);
        axi_read(4'hC, d, r);
        chk("clr_sticky", d, 32'h01);

        // Write to read-only STATUS
        axi_write(4'hC, 32'hFFFFFFFF, 4'hF, r); model_write(4'hC, 32'hFFFFFFFF, 4'hF, exp_r, exp_p);
        chk("ro_slverr", {30'd0, r}, 32'd2);
        axi_read(4'hC, d, r);
        chk("ro_unchanged", d, model_read(4'hC));

        // R back-pressure: data stable, single beat
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        tick(); arvalid = 1'b0;
        d0 = rdata;
        chk("rbp_data", d0, m_data_in);
        repeat (3) begin
            chk("rbp_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rbp_stable", rdata, d0);
            tick();
        end
        rready = 1'b1; tick(); rready = 1'b0;
        chk("rbp_single_beat", {31'd0, rvalid}, 32'd0);

        // Randomized traffic against the model with the core IDLE
        status = 2'd0; tick();
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom);
            e0 = en_cnt;
            axi_write(a, d, s, r); model_write(a, d, s, exp_r, exp_p);
            repeat (2) tick();
            chk("rnd_bresp", {30'd0, r}, {30'd0, exp_r});
            chk("rnd_pulse", 32'(en_cnt - e0), 32'(exp_p));
            chk("rnd_ipreg", ip_data_out, m_data_in);
            a = 4'($urandom_range(0, 15));
            exp_d = model_read(a);
            axi_read(a, d, r);
            chk("rnd_rdata", d, exp_d);
            chk("rnd_rresp", {30'd0, r}, 32'd0);
        end

        // Reset with an address held: state dropped, VALIDs low
        awaddr = 4'h4; awvalid = 1'b1;
        tick(); awvalid = 1'b0;
        chk("mid_aw_held", {31'd0, awready}, 32'd0);
        rst = 1'b1; tick();
        chk("mid_rst_awready", {31'd0, awready}, 32'd0);
        chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        rst = 1'b0; tick();
        m_data_in = '0; m_result = '0; m_done = 0; m_ign = 0;
        chk("mid_aw_dropped", {31'd0, awready}, 32'd1);
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        repeat (3) tick();
        chk("mid_no_commit", {31'd0, bvalid}, 32'd0);
        axi_read(4'h4, d, r);
        chk("mid_data_cleared", d, m_data_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
